// File: rtl/pipe_ctrl_hazard_if.sv
// Bundle of ID-stage inputs and per-stage control outputs shared between the
// pipeline datapath (master) and the control/hazard unit (slave).
interface pipe_ctrl_hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3,
    parameter int CNT_W      = 16
);
    logic [5:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  mem_branch_taken;
    logic                  cnt_clr;

    logic                  ex_reg_dst;
    logic                  ex_alu_src;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_branch;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic                  id_jump;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  illegal_op;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_opcode, id_rs, id_rt, mem_branch_taken, cnt_clr,
        input  ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write, mem_branch,
               wb_reg_write, wb_mem_to_reg, id_jump, pc_write, ifid_write, ifid_flush,
               illegal_op, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, mem_branch_taken, cnt_clr,
        output ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write, mem_branch,
               wb_reg_write, wb_mem_to_reg, id_jump, pc_write, ifid_write, ifid_flush,
               illegal_op, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// Pipelined MIPS main control: ID decode, control carried through ID/EX, EX/MEM, MEM/WB,
// load-use stall insertion, branch/jump flushing and saturating stall/flush event counters.
module pipe_ctrl_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    pipe_ctrl_hazard_if.slave bus
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                  dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
    logic                  dec_branch, dec_reg_write, dec_mem_to_reg, dec_jump;
    logic                  dec_illegal, dec_uses_rt;
    logic [ALU_OP_W-1:0]   dec_alu_op;

    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        dec_uses_rt    = 1'b0;
        dec_alu_op     = '0;
        case (bus.id_opcode)
            OP_R: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_uses_rt   = 1'b1;
                dec_alu_op    = ALU_OP_W'(2);
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_branch  = 1'b1;
                dec_uses_rt = 1'b1;
                dec_alu_op  = ALU_OP_W'(1);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                case (bus.id_opcode)
                    OP_ANDI: dec_alu_op = ALU_OP_W'(3);
                    OP_ORI:  dec_alu_op = ALU_OP_W'(4);
                    OP_XORI: dec_alu_op = ALU_OP_W'(5);
                    OP_SLTI: dec_alu_op = ALU_OP_W'(6);
                    default: dec_alu_op = '0;
                endcase
            end
            OP_J:    dec_jump    = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    // ID/EX (_p0), EX/MEM (_p1), MEM/WB (_p2) control registers
    logic                  reg_dst_p0, alu_src_p0, mem_read_p0, mem_write_p0;
    logic                  branch_p0, reg_write_p0, mem_to_reg_p0, illegal_p0;
    logic [ALU_OP_W-1:0]   alu_op_p0;
    logic [REG_ADDR_W-1:0] rt_p0;
    logic                  mem_read_p1, mem_write_p1, branch_p1, reg_write_p1, mem_to_reg_p1;
    logic                  reg_write_p2, mem_to_reg_p2;

    logic stall, flush, stall_eff, jump_eff, bubble_id;

    always_comb begin
        stall     = mem_read_p0 && (rt_p0 != '0) &&
                    ((rt_p0 == bus.id_rs) || ((rt_p0 == bus.id_rt) && dec_uses_rt));
        // Reset overrides every combinational redirect so the outputs sit at reset values.
        flush     = reset_n && bus.mem_branch_taken;
        stall_eff = reset_n && stall && !flush;
        jump_eff  = reset_n && dec_jump && !stall && !flush;
        bubble_id = flush || stall_eff;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_dst_p0    <= 1'b0;
            alu_src_p0    <= 1'b0;
            alu_op_p0     <= '0;
            mem_read_p0   <= 1'b0;
            mem_write_p0  <= 1'b0;
            branch_p0     <= 1'b0;
            reg_write_p0  <= 1'b0;
            mem_to_reg_p0 <= 1'b0;
            illegal_p0    <= 1'b0;
            rt_p0         <= '0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            branch_p1     <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
        end else begin
            if (bubble_id) begin
                reg_dst_p0    <= 1'b0;
                alu_src_p0    <= 1'b0;
                alu_op_p0     <= '0;
                mem_read_p0   <= 1'b0;
                mem_write_p0  <= 1'b0;
                branch_p0     <= 1'b0;
                reg_write_p0  <= 1'b0;
                mem_to_reg_p0 <= 1'b0;
                illegal_p0    <= 1'b0;
                rt_p0         <= '0;
            end else begin
                reg_dst_p0    <= dec_reg_dst;
                alu_src_p0    <= dec_alu_src;
                alu_op_p0     <= dec_alu_op;
                mem_read_p0   <= dec_mem_read;
                mem_write_p0  <= dec_mem_write;
                branch_p0     <= dec_branch;
                reg_write_p0  <= dec_reg_write;
                mem_to_reg_p0 <= dec_mem_to_reg;
                illegal_p0    <= dec_illegal;
                rt_p0         <= bus.id_rt;
            end
            if (flush) begin
                mem_read_p1   <= 1'b0;
                mem_write_p1  <= 1'b0;
                branch_p1     <= 1'b0;
                reg_write_p1  <= 1'b0;
                mem_to_reg_p1 <= 1'b0;
            end else begin
                mem_read_p1   <= mem_read_p0;
                mem_write_p1  <= mem_write_p0;
                branch_p1     <= branch_p0;
                reg_write_p1  <= reg_write_p0;
                mem_to_reg_p1 <= mem_to_reg_p0;
            end
            // The resolving branch itself still retires into MEM/WB.
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
        end
    end

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_eff)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush || jump_eff)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign bus.ex_reg_dst    = reg_dst_p0;
    assign bus.ex_alu_src    = alu_src_p0;
    assign bus.ex_alu_op     = alu_op_p0;
    assign bus.illegal_op    = illegal_p0;
    assign bus.mem_read      = mem_read_p1;
    assign bus.mem_write     = mem_write_p1;
    assign bus.mem_branch    = branch_p1;
    assign bus.wb_reg_write  = reg_write_p2;
    assign bus.wb_mem_to_reg = mem_to_reg_p2;
    assign bus.id_jump       = jump_eff;
    assign bus.pc_write      = !stall_eff;
    assign bus.ifid_write    = !stall_eff;
    assign bus.ifid_flush    = flush || jump_eff;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Randomized bench for pipe_ctrl_hazard_unit: an instruction-record pipeline model checked
// every cycle, plus directed scenarios with literal expectations; a CNT_W=2 copy checks saturation.
module tb_pipe_ctrl_hazard_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_hazard_if #(.REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(16)) bus ();
    pipe_ctrl_hazard_if #(.REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(2))  bus2 ();

    assign bus2.id_opcode        = bus.id_opcode;
    assign bus2.id_rs            = bus.id_rs;
    assign bus2.id_rt            = bus.id_rt;
    assign bus2.mem_branch_taken = bus.mem_branch_taken;
    assign bus2.cnt_clr          = bus.cnt_clr;

    pipe_ctrl_hazard_unit #(.REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    pipe_ctrl_hazard_unit #(.REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    typedef struct packed {
        logic       reg_dst, alu_src;
        logic [2:0] alu_op;
        logic       mem_read, mem_write, branch, reg_write, mem_to_reg, illegal;
        logic [4:0] rt;
    } instr_t;

    instr_t stage [3];  // instructions currently in EX, MEM, WB
    int stall_n, flush_n, stall_n2, flush_n2;
    int passed = 0;
    int total  = 0;

    localparam logic [5:0] R = 6'd0, LW = 6'd35, SW = 6'd43, BEQ = 6'd4, ADDI = 6'd8,
                           ANDI = 6'd12, ORI = 6'd13, XORI = 6'd14, SLTI = 6'd10, J = 6'd2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic instr_t decode(input logic [5:0] opc, input logic [4:0] rt);
        instr_t c = '0;
        c.rt = rt;
        if (opc == R) begin c.reg_dst = 1; c.reg_write = 1; c.alu_op = 3'd2; end
        else if (opc == LW) begin c.alu_src = 1; c.mem_to_reg = 1; c.reg_write = 1; c.mem_read = 1; end
        else if (opc == SW) begin c.alu_src = 1; c.mem_write = 1; end
        else if (opc == BEQ) begin c.branch = 1; c.alu_op = 3'd1; end
        else if (opc inside {ADDI, ANDI, ORI, XORI, SLTI}) begin
            c.alu_src = 1; c.reg_write = 1;
            c.alu_op = (opc == ADDI) ? 3'd0 : (opc == ANDI) ? 3'd3 : (opc == ORI) ? 3'd4 :
                       (opc == XORI) ? 3'd5 : 3'd6;
        end
        else if (opc != J) c.illegal = 1;
        return c;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Compare outputs for the inputs just driven, then advance the model across the next edge.
    task automatic model_step();
        logic [5:0] opc = bus.id_opcode;
        logic [4:0] rs = bus.id_rs, rt = bus.id_rt;
        logic br = bus.mem_branch_taken;
        logic clr = bus.cnt_clr;
        logic ld_hz, st, jp;
        logic [14:0] exp_v, act_v;
        ld_hz = stage[0].mem_read && stage[0].rt != 0 &&
                (stage[0].rt == rs || (stage[0].rt == rt && opc inside {R, SW, BEQ}));
        st = ld_hz && !br;
        jp = (opc == J) && !ld_hz && !br;
        exp_v = {stage[0].reg_dst, stage[0].alu_src, stage[0].alu_op, stage[1].mem_read,
                 stage[1].mem_write, stage[1].branch, stage[2].reg_write, stage[2].mem_to_reg,
                 jp, !st, !st, br || jp, stage[0].illegal};
        act_v = {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op, bus.mem_read, bus.mem_write,
                 bus.mem_branch, bus.wb_reg_write, bus.wb_mem_to_reg, bus.id_jump, bus.pc_write,
                 bus.ifid_write, bus.ifid_flush, bus.illegal_op};
        chk("model_controls", 64'(act_v), 64'(exp_v));
        chk("model_counters", {32'(bus.stall_cnt), 32'(bus.flush_cnt)},
            {32'(stall_n), 32'(flush_n)});
        chk("model_sat_counters", {32'(bus2.stall_cnt), 32'(bus2.flush_cnt)},
            {32'(stall_n2), 32'(flush_n2)});
        stage[2] = stage[1];
        stage[1] = br ? '0 : stage[0];
        stage[0] = (br || st) ? '0 : decode(opc, rt);
        if (clr) begin
            stall_n = 0; flush_n = 0; stall_n2 = 0; flush_n2 = 0;
        end else begin
            stall_n  = sat(stall_n + int'(st), 65535);
            stall_n2 = sat(stall_n2 + int'(st), 3);
            flush_n  = sat(flush_n + int'(br || jp), 65535);
            flush_n2 = sat(flush_n2 + int'(br || jp), 3);
        end
    endtask

    task automatic cycle(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic clr);
        @(negedge clk);
        bus.id_opcode = opc; bus.id_rs = rs; bus.id_rt = rt;
        bus.mem_branch_taken = br; bus.cnt_clr = clr;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_ex_alu_src", 64'(bus.ex_alu_src), 64'd0);
        chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
        chk("rst_wb_reg_write", 64'(bus.wb_reg_write), 64'd0);
        chk("rst_pc_write", 64'(bus.pc_write), 64'd1);
        chk("rst_ifid_flush", 64'(bus.ifid_flush), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        for (int i = 0; i < 3; i++) stage[i] = '0;
        stall_n = 0; flush_n = 0; stall_n2 = 0; flush_n2 = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.id_opcode = R; bus.id_rs = 0; bus.id_rt = 0;
        bus.mem_branch_taken = 0; bus.cnt_clr = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Load-use stall: LW rt=8 then ADD rs=8.
        cycle(LW, 5'd1, 5'd8, 0, 0);
        chk("lw_no_stall_pc_write", 64'(bus.pc_write), 64'd1);
        cycle(R, 5'd8, 5'd2, 0, 0);
        chk("lu_pc_write", 64'(bus.pc_write), 64'd0);
        chk("lu_ifid_write", 64'(bus.ifid_write), 64'd0);
        cycle(R, 5'd8, 5'd2, 0, 0);
        chk("lu_bubble_ex_reg_dst", 64'(bus.ex_reg_dst), 64'd0);
        chk("lu_bubble_ex_alu_op", 64'(bus.ex_alu_op), 64'd0);
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 64'd1);
        chk("lu_one_cycle_only", 64'(bus.pc_write), 64'd1);

        // No stall cases.
        cycle(LW, 5'd1, 5'd0, 0, 0);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("rt0_no_stall", 64'(bus.pc_write), 64'd1);
        cycle(LW, 5'd1, 5'd8, 0, 0);
        cycle(ADDI, 5'd3, 5'd8, 0, 0);
        chk("addi_rt_no_stall", 64'(bus.pc_write), 64'd1);

        // ADDI / SW latency.
        cycle(SW, 5'd0, 5'd0, 0, 0);
        chk("addi_ex_alu_src", 64'(bus.ex_alu_src), 64'd1);
        chk("addi_ex_alu_op", 64'(bus.ex_alu_op), 64'd0);
        cycle(R, 5'd0, 5'd0, 0, 0);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("addi_wb_reg_write", 64'(bus.wb_reg_write), 64'd1);
        chk("sw_mem_write", 64'(bus.mem_write), 64'd1);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("sw_wb_reg_write", 64'(bus.wb_reg_write), 64'd0);

        // Branch flush beats a load-use hazard and a J in ID.
        cycle(LW, 5'd1, 5'd8, 0, 1);
        cycle(J, 5'd8, 5'd0, 1, 0);
        chk("fl_ifid_flush", 64'(bus.ifid_flush), 64'd1);
        chk("fl_pc_write", 64'(bus.pc_write), 64'd1);
        chk("fl_id_jump", 64'(bus.id_jump), 64'd0);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("fl_ex_bubble", 64'(bus.ex_alu_src), 64'd0);
        chk("fl_mem_bubble", 64'(bus.mem_read), 64'd0);
        chk("fl_flush_cnt", 64'(bus.flush_cnt), 64'd1);
        chk("fl_stall_cnt", 64'(bus.stall_cnt), 64'd0);

        // Plain jump.
        cycle(J, 5'd0, 5'd0, 0, 0);
        chk("j_id_jump", 64'(bus.id_jump), 64'd1);
        chk("j_ifid_flush", 64'(bus.ifid_flush), 64'd1);

        // Illegal opcode.
        cycle(6'b111111, 5'd0, 5'd0, 0, 0);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("ill_illegal_op", 64'(bus.illegal_op), 64'd1);
        chk("ill_ex_reg_dst", 64'(bus.ex_reg_dst), 64'd0);

        // Saturation on the CNT_W=2 copy, then clear beating a same-cycle stall.
        cycle(R, 5'd0, 5'd0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(LW, 5'd1, 5'd8, 0, 0);
            cycle(R, 5'd8, 5'd2, 0, 0);
        end
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("sat_stall_cnt2", 64'(bus2.stall_cnt), 64'd3);
        chk("sat_stall_cnt16", 64'(bus.stall_cnt), 64'd5);
        cycle(LW, 5'd1, 5'd8, 0, 0);
        cycle(R, 5'd8, 5'd2, 0, 1);
        cycle(R, 5'd0, 5'd0, 0, 0);
        chk("clr_beats_stall2", 64'(bus2.stall_cnt), 64'd0);
        chk("clr_beats_stall16", 64'(bus.stall_cnt), 64'd0);

        // Reset mid-stream with a load and an immediate in flight.
        cycle(LW, 5'd1, 5'd9, 0, 0);
        cycle(ADDI, 5'd2, 5'd3, 0, 0);
        cycle(J, 5'd0, 5'd0, 0, 0);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] opc;
            int pick = $urandom_range(0, 11);
            case (pick)
                0: opc = R;    1: opc = LW;   2: opc = SW;   3: opc = BEQ;
                4: opc = ADDI; 5: opc = ANDI; 6: opc = ORI;  7: opc = XORI;
                8: opc = SLTI; 9: opc = J;    10: opc = LW;
                default: opc = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
